mem_arbiter: RTL and testbench

Two-requester round-robin front end for the 16x8 command/data memory. It accepts independent valid/ready request streams, grants at most one memory operation per cycle, and drives the memory's `wr`/`addr`/`din` pins. It returns read data and write acknowledgements with fixed latency and protects the command region (addresses 0-3) against writes from the secondary requester.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//    Two-requester round-robin front end for a 16x8 command/data memory.
//    Grants at most one memory operation per cycle and drives the memory pins.
//    Read data and write acknowledgements come back one cycle after
//    acceptance on the requesting port. Port 1 writes into the command
//    region can be rejected.
//
// Parameters
//    CMD_WORDS    addresses 0..CMD_WORDS-1 form the command region
//    CMD_LOCK     1: port 1 writes into the command region are rejected
//
// Ports
//    clk, rst                         clock, synchronous active-high reset
//    req_valid_N / req_ready_N        request handshake, port N in {0,1}
//    req_wr_N, req_addr_N, req_wdata_N
//                                     request body: write flag, word address, write data
//    rsp_valid_N, rsp_rdata_N, rsp_err_N
//                                     one-cycle response pulse, read data, rejection flag
//    mem_wr, mem_addr, mem_din        memory command pins
//    mem_dout                         registered memory read data
module mem_arbiter #(
   parameter int CMD_WORDS = 4,
   parameter bit CMD_LOCK  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,

   input  logic       req_valid_0,
   output logic       req_ready_0,
   input  logic       req_wr_0,
   input  logic [3:0] req_addr_0,
   input  logic [7:0] req_wdata_0,

   input  logic       req_valid_1,
   output logic       req_ready_1,
   input  logic       req_wr_1,
   input  logic [3:0] req_addr_1,
   input  logic [7:0] req_wdata_1,

   output logic       rsp_valid_0,
   output logic [7:0] rsp_rdata_0,
   output logic       rsp_err_0,

   output logic       rsp_valid_1,
   output logic [7:0] rsp_rdata_1,
   output logic       rsp_err_1,

   output logic       mem_wr,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_din,
   input  logic [7:0] mem_dout
);

   localparam logic [4:0] CMD_LIMIT = 5'(CMD_WORDS);

   logic       prio;
   logic       grant_0;
   logic       grant_1;
   logic       any_grant;
   logic       sel_wr;
   logic [3:0] sel_addr;
   logic [7:0] sel_wdata;
   logic       reject;

   logic       rsp_v_q;
   logic       rsp_port_q;
   logic       rsp_rd_q;
   logic       rsp_err_q;
   logic       rsp_live;

   // Arbitration: a lone requester always wins; on contention prio decides.
   // Nothing is granted while rst is high.
   always_comb begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      if (!rst) begin
         if (req_valid_0 && req_valid_1) begin
            grant_0 = ~prio;
            grant_1 = prio;
         end else begin
            grant_0 = req_valid_0;
            grant_1 = req_valid_1;
         end
      end
   end

   assign any_grant   = grant_0 | grant_1;
   assign req_ready_0 = grant_0;
   assign req_ready_1 = grant_1;

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (grant_0) begin
         sel_wr    = req_wr_0;
         sel_addr  = req_addr_0;
         sel_wdata = req_wdata_0;
      end else if (grant_1) begin
         sel_wr    = req_wr_1;
         sel_addr  = req_addr_1;
         sel_wdata = req_wdata_1;
      end
   end

   // A rejected write still completes its handshake; it just never reaches
   // the memory write strobe.
   always_comb begin
      reject = 1'b0;
      if (CMD_LOCK && grant_1 && req_wr_1 && ({1'b0, req_addr_1} < CMD_LIMIT))
         reject = 1'b1;
   end

   // Idle cycles present address 0 with wr low: a harmless read whose
   // result is never forwarded.
   always_comb begin
      mem_wr   = any_grant & sel_wr & ~reject;
      mem_addr = sel_addr;
      mem_din  = mem_wr ? sel_wdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio       <= 1'b0;
         rsp_v_q    <= 1'b0;
         rsp_port_q <= 1'b0;
         rsp_rd_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (grant_0)
            prio <= 1'b1;
         else if (grant_1)
            prio <= 1'b0;
         rsp_v_q    <= any_grant;
         rsp_port_q <= grant_1;
         rsp_rd_q   <= any_grant & ~sel_wr;
         rsp_err_q  <= reject;
      end
   end

   // Gating with rst drops a response whose request was accepted just
   // before reset rose.
   assign rsp_live = rsp_v_q & ~rst;

   always_comb begin
      rsp_valid_0 = rsp_live & ~rsp_port_q;
      rsp_valid_1 = rsp_live &  rsp_port_q;
      rsp_err_0   = rsp_valid_0 & rsp_err_q;
      rsp_err_1   = rsp_valid_1 & rsp_err_q;
      rsp_rdata_0 = (rsp_valid_0 && rsp_rd_q) ? mem_dout : '0;
      rsp_rdata_1 = (rsp_valid_1 && rsp_rd_q) ? mem_dout : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
   logic [3:0] a0 = '0, a1 = '0;
   logic [7:0] d0 = '0, d1 = '0;

   // instance A: CMD_LOCK = 1
   logic       rdy0, rdy1, rv0, rv1, re0, re1, m_wr;
   logic [7:0] rd0, rd1, m_din;
   logic [3:0] m_addr;
   logic [7:0] m_dout = 8'h00;
   logic [7:0] mem_a [16] = '{default: 8'h00};

   // instance B: CMD_LOCK = 0, same stimulus
   logic       b_rdy0, b_rdy1, b_rv0, b_rv1, b_re0, b_re1, b_wr;
   logic [7:0] b_rd0, b_rd1, b_din;
   logic [3:0] b_addr;
   logic [7:0] b_dout = 8'h00;
   logic [7:0] mem_b [16] = '{default: 8'h00};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.CMD_WORDS(4), .CMD_LOCK(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid_0(v0), .req_ready_0(rdy0), .req_wr_0(w0), .req_addr_0(a0), .req_wdata_0(d0),
      .req_valid_1(v1), .req_ready_1(rdy1), .req_wr_1(w1), .req_addr_1(a1), .req_wdata_1(d1),
      .rsp_valid_0(rv0), .rsp_rdata_0(rd0), .rsp_err_0(re0),
      .rsp_valid_1(rv1), .rsp_rdata_1(rd1), .rsp_err_1(re1),
      .mem_wr(m_wr), .mem_addr(m_addr), .mem_din(m_din), .mem_dout(m_dout));

   mem_arbiter #(.CMD_WORDS(4), .CMD_LOCK(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid_0(v0), .req_ready_0(b_rdy0), .req_wr_0(w0), .req_addr_0(a0), .req_wdata_0(d0),
      .req_valid_1(v1), .req_ready_1(b_rdy1), .req_wr_1(w1), .req_addr_1(a1), .req_wdata_1(d1),
      .rsp_valid_0(b_rv0), .rsp_rdata_0(b_rd0), .rsp_err_0(b_re0),
      .rsp_valid_1(b_rv1), .rsp_rdata_1(b_rd1), .rsp_err_1(b_re1),
      .mem_wr(b_wr), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(b_dout));

   // 16x8 memories with registered, read-first dout
   always @(posedge clk) begin
      if (m_wr) mem_a[m_addr] <= m_din;
      m_dout <= mem_a[m_addr];
      if (b_wr) mem_b[b_addr] <= b_din;
      b_dout <= mem_b[b_addr];
   end

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk8(name, {7'd0, act}, {7'd0, exp});
   endtask

   // ---------------- transaction-level reference model (instance A) -------
   logic       m_prio = 1'b0;
   logic [7:0] m_mem [16] = '{default: 8'h00};
   logic       p_v = 1'b0, p_port = 1'b0, p_err = 1'b0;
   logic [7:0] p_data = 8'h00;

   task automatic model_check();
      logic g0, g1, rej, ewr;
      logic [3:0] eaddr;
      logic [7:0] edin;
      logic e_v0, e_v1;
      e_v0 = !rst && p_v && !p_port;
      e_v1 = !rst && p_v &&  p_port;
      chk1("rsp_valid_0", rv0, e_v0);
      chk1("rsp_valid_1", rv1, e_v1);
      chk8("rsp_rdata_0", rd0, e_v0 ? p_data : 8'h00);
      chk8("rsp_rdata_1", rd1, e_v1 ? p_data : 8'h00);
      chk1("rsp_err_0", re0, e_v0 && p_err);
      chk1("rsp_err_1", re1, e_v1 && p_err);

      g0 = 1'b0; g1 = 1'b0;
      if (!rst) begin
         if (v0 && v1) begin
            if (m_prio) g1 = 1'b1; else g0 = 1'b1;
         end else if (v0) g0 = 1'b1;
         else if (v1) g1 = 1'b1;
      end
      rej   = g1 && w1 && (a1 < 4'd4);
      ewr   = (g0 && w0) || (g1 && w1 && !rej);
      eaddr = g0 ? a0 : (g1 ? a1 : 4'd0);
      edin  = g0 ? d0 : d1;
      chk1("req_ready_0", rdy0, g0);
      chk1("req_ready_1", rdy1, g1);
      chk1("mem_wr", m_wr, ewr);
      chk8("mem_addr", {4'd0, m_addr}, {4'd0, eaddr});
      if (ewr) chk8("mem_din", m_din, edin);
      if (!g0 && !g1) chk8("mem_din_idle", m_din, 8'h00);

      if (rst) begin
         p_v = 1'b0;
         m_prio = 1'b0;
      end else begin
         p_v    = g0 || g1;
         p_port = g1;
         p_err  = rej;
         p_data = 8'h00;
         if (g0 && !w0) p_data = m_mem[a0];
         if (g1 && !w1) p_data = m_mem[a1];
         if (ewr) m_mem[eaddr] = edin;
         if (g0) m_prio = 1'b1;
         else if (g1) m_prio = 1'b0;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic nv0, input logic nw0, input logic [3:0] na0, input logic [7:0] nd0,
                        input logic nv1, input logic nw1, input logic [3:0] na1, input logic [7:0] nd1);
      v0 = nv0; w0 = nw0; a0 = na0; d0 = nd0;
      v1 = nv1; w1 = nw1; a1 = na1; d1 = nd1;
   endtask

   // ---------------- directed table ----------------------------------------
   typedef struct {
      logic v0, w0; logic [3:0] a0; logic [7:0] d0;
      logic v1, w1; logic [3:0] a1; logic [7:0] d1;
      logic er0, er1, ewr; logic [3:0] ea;
      logic ev0; logic [7:0] ed0; logic ee0;
      logic ev1; logic [7:0] ed1; logic ee1;
   } vec_t;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   vec_t tbl [13];

   initial begin
      tbl[0]  = '{T,T,4'h5,8'hA5, F,F,4'h0,8'h00, T,F,T,4'h5, F,8'h00,F, F,8'h00,F};
      tbl[1]  = '{T,F,4'h5,8'h00, F,F,4'h0,8'h00, T,F,F,4'h5, T,8'h00,F, F,8'h00,F};
      tbl[2]  = '{F,F,4'h0,8'h00, F,F,4'h0,8'h00, F,F,F,4'h0, T,8'hA5,F, F,8'h00,F};
      tbl[3]  = '{F,F,4'h0,8'h00, T,T,4'h2,8'h3C, F,T,F,4'h2, F,8'h00,F, F,8'h00,F};
      tbl[4]  = '{T,F,4'h2,8'h00, F,F,4'h0,8'h00, T,F,F,4'h2, F,8'h00,F, T,8'h00,T};
      tbl[5]  = '{F,F,4'h0,8'h00, T,T,4'hC,8'h77, F,T,T,4'hC, T,8'h00,F, F,8'h00,F};
      tbl[6]  = '{T,F,4'hC,8'h00, F,F,4'h0,8'h00, T,F,F,4'hC, F,8'h00,F, T,8'h00,F};
      tbl[7]  = '{T,T,4'h9,8'h5A, F,F,4'h0,8'h00, T,F,T,4'h9, T,8'h77,F, F,8'h00,F};
      tbl[8]  = '{T,F,4'h9,8'h00, F,F,4'h0,8'h00, T,F,F,4'h9, T,8'h00,F, F,8'h00,F};
      tbl[9]  = '{T,F,4'h5,8'h00, T,F,4'hC,8'h00, F,T,F,4'hC, T,8'h5A,F, F,8'h00,F};
      tbl[10] = '{T,F,4'h5,8'h00, T,F,4'hC,8'h00, T,F,F,4'h5, F,8'h00,F, T,8'h77,F};
      tbl[11] = '{F,F,4'h0,8'h00, F,F,4'h0,8'h00, F,F,F,4'h0, T,8'hA5,F, F,8'h00,F};
      tbl[12] = '{F,F,4'h0,8'h00, F,F,4'h0,8'h00, F,F,F,4'h0, F,8'h00,F, F,8'h00,F};

      // reset
      rst = 1'b1;
      advance();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk1("reset_ready_0", rdy0, 1'b0);
         chk1("reset_rsp_valid_0", rv0, 1'b0);
         advance();
      end
      rst = 1'b0;

      // directed vectors from a freshly reset state
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
         sample();
         chk1("tbl_ready_0", rdy0, tbl[i].er0);
         chk1("tbl_ready_1", rdy1, tbl[i].er1);
         chk1("tbl_mem_wr", m_wr, tbl[i].ewr);
         chk8("tbl_mem_addr", {4'd0, m_addr}, {4'd0, tbl[i].ea});
         if (tbl[i].ewr) chk8("tbl_mem_din", m_din, tbl[i].er0 ? tbl[i].d0 : tbl[i].d1);
         chk1("tbl_rsp_valid_0", rv0, tbl[i].ev0);
         chk8("tbl_rsp_rdata_0", rd0, tbl[i].ed0);
         chk1("tbl_rsp_err_0", re0, tbl[i].ee0);
         chk1("tbl_rsp_valid_1", rv1, tbl[i].ev1);
         chk8("tbl_rsp_rdata_1", rd1, tbl[i].ed1);
         chk1("tbl_rsp_err_1", re1, tbl[i].ee1);
         advance();
      end

      // round-robin from reset: grants must alternate 0,1,0,1,0,1
      rst = 1'b1;
      drive(F,F,4'h0,8'h00, F,F,4'h0,8'h00);
      sample();
      advance();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(T,F,4'(i),8'h00, T,F,4'(15 - i),8'h00);
         sample();
         chk1("rr_ready_0", rdy0, (i % 2) == 0);
         chk1("rr_ready_1", rdy1, (i % 2) == 1);
         if (i > 0) begin
            chk1("rr_rsp_valid_0", rv0, (i % 2) == 1);
            chk1("rr_rsp_valid_1", rv1, (i % 2) == 0);
         end
         advance();
      end
      drive(F,F,4'h0,8'h00, F,F,4'h0,8'h00);
      sample();
      chk1("rr_last_rsp_valid_1", rv1, 1'b1);
      advance();

      // reset mid-flight: port 1 read accepted, then rst drops its response
      drive(F,F,4'h0,8'h00, T,F,4'hC,8'h00);
      sample();
      chk1("mf_ready_1", rdy1, 1'b1);
      advance();
      rst = 1'b1;
      drive(T,F,4'h3,8'h00, T,F,4'h4,8'h00);
      sample();
      chk1("mf_rsp_valid_1", rv1, 1'b0);
      chk8("mf_rsp_rdata_1", rd1, 8'h00);
      chk1("mf_no_accept", rdy0 | rdy1, 1'b0);
      advance();
      rst = 1'b0;
      // move prio to 1, then reset again: the first contested grant must go to port 0
      drive(T,F,4'h3,8'h00, F,F,4'h0,8'h00);
      sample();
      advance();
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
      drive(T,F,4'h3,8'h00, T,F,4'h4,8'h00);
      sample();
      chk1("post_reset_grant_0", rdy0, 1'b1);
      advance();
      drive(F,F,4'h0,8'h00, F,F,4'h0,8'h00);
      sample();
      advance();

      // CMD_LOCK=0 instance accepts port 1 writes into the command region
      drive(F,F,4'h0,8'h00, T,T,4'h0,8'h11);
      sample();
      chk1("nolock_mem_wr", b_wr, 1'b1);
      chk8("nolock_mem_din", b_din, 8'h11);
      advance();
      drive(T,F,4'h0,8'h00, F,F,4'h0,8'h00);
      sample();
      chk1("nolock_rsp_err_1", b_re1, 1'b0);
      chk1("lock_rsp_err_1", re1, 1'b1);
      advance();
      drive(F,F,4'h0,8'h00, F,F,4'h0,8'h00);
      sample();
      chk8("nolock_readback", b_rd0, 8'h11);
      chk8("lock_readback", rd0, 8'h00);
      advance();

      // randomized traffic against the model, with occasional resets
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         drive(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
         sample();
         chk1("rand_one_ready", rdy0 & rdy1, 1'b0);
         advance();
      end
      rst = 1'b0;
      drive(F,F,4'h0,8'h00, F,F,4'h0,8'h00);
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
